// File: rtl/floor_request_latch.sv
// floor_request_latch
//   Turns raw floor-call buttons into the pending-request mask shown by the
//   VGA path. Buttons are synchronized, debounced on a slow sample tick, and
//   latched as request bits until the elevator controller reports the floor
//   as serviced.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   buttons      : raw asynchronous call buttons (active-high)
//   clear_en     : one-cycle strobe, floor clear_floor has been serviced
//   clear_floor  : serviced floor index (values >= FLOORS are ignored)
//   destination  : pending request mask, bit i = floor i
//   req_valid    : any request pending
//   next_floor   : lowest pending floor index, 0 when none
//   req_pulse    : one-cycle strobe when a new request bit is set

// Per-button synchronizer + debouncer. acc_o flags a newly accepted press
// for the cycle whose edge commits it.
module floor_request_lane (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  input  logic tick_i,
  output logic acc_o
);
  logic sync1_q, sync2_q, samp_q, stable_q;

  // Pressed level seen on this tick and the previous one, not yet debounced high.
  assign acc_o = tick_i & sync2_q & samp_q & ~stable_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      samp_q   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (tick_i) begin
        samp_q <= sync2_q;
        if (sync2_q == samp_q) stable_q <= sync2_q;
      end
    end
  end
endmodule

module floor_request_latch #(
  parameter int FLOORS          = 16,
  parameter int FLOOR_W         = $clog2(FLOORS),
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOORS-1:0]  buttons,
  input  logic               clear_en,
  input  logic [FLOOR_W-1:0] clear_floor,
  output logic [FLOORS-1:0]  destination,
  output logic               req_valid,
  output logic [FLOOR_W-1:0] next_floor,
  output logic               req_pulse
);
  localparam logic [CNT_W-1:0]   TICK_AT   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FLOOR_W:0]   FLOORS_LIM = (FLOOR_W + 1)'(FLOORS);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick;
  logic [FLOORS-1:0] acc, clr_mask;
  logic [FLOORS-1:0] dest_q, dest_d;
  logic              pulse_q, pulse_d;

  // Sample-tick prescaler: exactly one tick per DEBOUNCE_CYCLES clocks.
  assign tick  = (cnt_q == TICK_AT);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  for (genvar i = 0; i < FLOORS; i++) begin : g_lane
    floor_request_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (buttons[i]),
      .tick_i (tick),
      .acc_o  (acc[i])
    );
  end

  // Out-of-range clear indices decode to an empty mask.
  always_comb begin
    clr_mask = '0;
    if (clear_en && ({1'b0, clear_floor} < FLOORS_LIM)) begin
      for (int i = 0; i < FLOORS; i++)
        if (clear_floor == FLOOR_W'(i)) clr_mask[i] = 1'b1;
    end
  end

  // Set beats clear on a collision; the pulse only reports bits that were 0.
  assign dest_d  = (dest_q & ~clr_mask) | acc;
  assign pulse_d = |(acc & ~dest_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      dest_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      pulse_q <= pulse_d;
    end
  end

  // Lowest-index priority encoder: scan downward so the lowest set bit wins.
  always_comb begin
    next_floor = '0;
    for (int i = FLOORS - 1; i >= 0; i--)
      if (dest_q[i]) next_floor = FLOOR_W'(i);
  end

  assign destination = dest_q;
  assign req_valid   = |dest_q;
  assign req_pulse   = pulse_q;
endmodule

// File: tb/tb_floor_request_latch.sv
module tb_floor_request_latch;
  localparam int FL = 16;
  localparam int FW = 5;   // wide enough to express clear_floor >= FLOORS
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [FL-1:0] buttons;
  logic          clear_en;
  logic [FW-1:0] clear_floor;
  logic [FL-1:0] destination;
  logic          req_valid;
  logic [FW-1:0] next_floor;
  logic          req_pulse;

  floor_request_latch #(.FLOORS(FL), .FLOOR_W(FW), .DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .buttons(buttons), .clear_en(clear_en),
    .clear_floor(clear_floor), .destination(destination), .req_valid(req_valid),
    .next_floor(next_floor), .req_pulse(req_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int pulse_cnt = 0;

  // Reference model: cycles since reset, button history seen through the
  // two-clock synchronizer delay, level seen on the previous tick, accepted
  // (debounced) level, and the request mask.
  int            m_phase;
  logic [FL-1:0] m_dly1, m_dly2, m_prev_tick_lvl, m_deb, m_dest;
  logic          m_pulse;

  function automatic int lowest(input logic [FL-1:0] m);
    for (int i = 0; i < FL; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [FL-1:0] lvl, newly, clr;
    if (rst) begin
      m_phase = 0; m_dly1 = '0; m_dly2 = '0; m_prev_tick_lvl = '0;
      m_deb = '0; m_dest = '0; m_pulse = 1'b0;
    end else begin
      lvl   = m_dly2;
      newly = '0;
      if (m_phase == D - 1) begin
        for (int i = 0; i < FL; i++) begin
          if (lvl[i] && m_prev_tick_lvl[i] && !m_deb[i]) newly[i] = 1'b1;
          if (lvl[i] == m_prev_tick_lvl[i]) m_deb[i] = lvl[i];
        end
        m_prev_tick_lvl = lvl;
      end
      clr = '0;
      if (clear_en && int'(clear_floor) < FL) clr[clear_floor] = 1'b1;
      m_pulse = |(newly & ~m_dest);
      m_dest  = (m_dest & ~clr) | newly;
      m_dly2  = m_dly1;
      m_dly1  = buttons;
      m_phase = (m_phase + 1) % D;
    end
  endtask

  // One clock: model follows the edge, outputs are compared 1 unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    if (req_pulse === 1'b1) pulse_cnt++;
    chk("model_dest",  32'(destination), 32'(m_dest));
    chk("model_pulse", 32'(req_pulse),   32'(m_pulse));
    chk("model_valid", 32'(req_valid),   32'(|m_dest));
    chk("model_next",  32'(next_floor),  32'(lowest(m_dest)));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; buttons = '0; clear_en = 1'b0; clear_floor = '0;
    repeat (n) cyc();
    rst = 1'b0;
  endtask

  task automatic clear1(input int f);
    clear_en = 1'b1; clear_floor = FW'(f);
    cyc();
    clear_en = 1'b0; clear_floor = '0;
  endtask

  initial begin
    int lat, gap;
    bit hit;
    rst = 1'b1; buttons = '0; clear_en = 1'b0; clear_floor = '0;

    // Reset holds everything low even with every button pressed.
    buttons = '1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rst_dest",  32'(destination), 32'h0);
      chk("rst_pulse", 32'(req_pulse),   32'h0);
      chk("rst_next",  32'(next_floor),  32'h0);
    end
    rst = 1'b0; pulse_cnt = 0;
    repeat (10) cyc();
    chk("rel_dest_all",  32'(destination), 32'hFFFF);
    chk("rel_one_pulse", 32'(pulse_cnt),   32'd1);

    // Single press on floor 5.
    do_reset(2);
    repeat (3) cyc();
    pulse_cnt = 0; lat = 0;
    buttons[5] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (lat == 0 && destination === 16'h0020) lat = k;
    end
    chk("press_lat_max", 32'(lat >= 1 && lat <= 2 + 2 * D), 32'd1);
    chk("press_lat_min", 32'(lat >= D + 2), 32'd1);
    chk("press_dest",    32'(destination), 32'h0020);
    chk("press_next",    32'(next_floor),  32'd5);
    chk("press_valid",   32'(req_valid),   32'd1);
    chk("press_pulses",  32'(pulse_cnt),   32'd1);
    buttons[5] = 1'b0;
    repeat (12) cyc();
    chk("press_sticky",  32'(destination), 32'h0020);

    // Add floor 8, then clear 5, out-of-range 17, then 8.
    buttons[8] = 1'b1;
    repeat (12) cyc();
    buttons[8] = 1'b0;
    repeat (12) cyc();
    chk("clr_setup", 32'(destination), 32'h0120);
    clear1(5);
    chk("clr5_dest", 32'(destination), 32'h0100);
    chk("clr5_next", 32'(next_floor),  32'd8);
    clear1(17);
    chk("clr17_dest", 32'(destination), 32'h0100);
    clear1(8);
    chk("clr8_dest",  32'(destination), 32'h0);
    chk("clr8_valid", 32'(req_valid),   32'h0);

    // Glitch rejection: 3-cycle pulses at random phases never register.
    do_reset(2);
    pulse_cnt = 0;
    for (int g = 0; g < 50; g++) begin
      gap = $urandom_range(6, 15);
      repeat (gap) cyc();
      buttons[3] = 1'b1;
      repeat (3) cyc();
      buttons[3] = 1'b0;
    end
    repeat (12) cyc();
    chk("glitch_dest",   32'(destination), 32'h0);
    chk("glitch_pulses", 32'(pulse_cnt),   32'd0);

    // Set/clear collision on floor 2: clear lands on the accepting edge.
    do_reset(2);
    buttons[2] = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (m_phase == D - 1 && m_dly2[2] && m_prev_tick_lvl[2] && !m_deb[2]) begin
        clear1(2);
        chk("coll_dest2", 32'(destination[2]), 32'd1);
        chk("coll_pulse", 32'(req_pulse),      32'd1);
        hit = 1'b1;
      end else begin
        cyc();
      end
    end
    chk("coll_reached", 32'(hit), 32'd1);
    buttons[2] = 1'b0;
    repeat (12) cyc();

    // Hold floor 7, clear while held, release, re-press.
    do_reset(2);
    pulse_cnt = 0;
    buttons[7] = 1'b1;
    repeat (100) cyc();
    chk("hold_pulses", 32'(pulse_cnt),      32'd1);
    chk("hold_bit",    32'(destination[7]), 32'd1);
    clear1(7);
    repeat (20) cyc();
    chk("hold_clr_bit", 32'(destination[7]), 32'd0);
    buttons[7] = 1'b0;
    repeat (10) cyc();
    buttons[7] = 1'b1;
    repeat (12) cyc();
    chk("repress_bit",    32'(destination[7]), 32'd1);
    chk("repress_pulses", 32'(pulse_cnt),      32'd2);
    buttons[7] = 1'b0;

    // Random buttons and clears against the model.
    do_reset(2);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) buttons[$urandom_range(0, FL - 1)] ^= 1'b1;
      clear_en    = ($urandom_range(0, 5) == 0);
      clear_floor = FW'($urandom_range(0, 19));
      if (k == 300) rst = 1'b1;
      if (k == 302) rst = 1'b0;
      cyc();
    end
    clear_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
